mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning the number of 32-bit words stored (power of two).
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning the number of wait cycles between request acceptance and response (0..15).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 The block SHALL have port mem_read, input, 1 bit, read request from the initiator.
REQ-006 The block SHALL have port mem_write, input, 1 bit, write request from the initiator.
REQ-007 The block SHALL have port addr, input, 32 bits, byte address of the access.
REQ-008 The block SHALL have port wdata, input, 32 bits, write data.
REQ-009 The block SHALL have port rdata, output, 32 bits, read data, valid when ready=1 for a read.
REQ-010 The block SHALL have port ready, output, 1 bit, one-cycle completion pulse.

Function
REQ-011 The block SHALL implement states IDLE, WAIT, DONE.
REQ-012 In IDLE, if mem_read or mem_write is 1, the block SHALL capture addr, wdata and the request type, then go to WAIT (LATENCY>0) or DONE (LATENCY=0).
REQ-013 If mem_read and mem_write are both 1 at capture, the block SHALL treat the request as a write.
REQ-014 In WAIT, a down-counter loaded with LATENCY-1 SHALL decrement each cycle; at 0 the block SHALL go to DONE.
REQ-015 In DONE, ready SHALL be 1 for exactly one cycle; next state SHALL be IDLE; ready SHALL be 0 in every other state.
REQ-016 Total latency SHALL be LATENCY+1 cycles from the capturing edge to the edge ending the ready-high cycle; a new request SHALL NOT be captured earlier than the cycle after DONE.
REQ-017 Inputs changing after capture SHALL have no effect on the in-flight access.
REQ-018 Word index SHALL be addr[log2(DEPTH)+1:2]; upper address bits SHALL be ignored, so addresses wrap modulo 4*DEPTH bytes; addr[1:0] SHALL be ignored.
REQ-019 A write SHALL update storage on the edge that enters DONE; during its ready cycle rdata SHALL hold its previous value.
REQ-020 A read SHALL drive rdata with the stored word from the edge that enters DONE, and rdata SHALL hold that value until the next read completes.
REQ-021 A read issued directly after a write to the same index SHALL return the newly written data.

Reset
REQ-022 On rst=1, the block SHALL immediately set state IDLE, ready=0, rdata=0 and counter=0.
REQ-023 Reset during WAIT SHALL abort the access with no storage update; storage contents SHALL NOT be reset.

Configuration
REQ-024 With macro MEM_RESPONDER_ALIGN_CHK_EN defined, the block SHALL add output err (1 bit, reset 0), set to 1 together with ready when the captured addr[1:0] is nonzero, and SHALL suppress the storage write for such a request; rdata SHALL be unchanged.
REQ-025 Without MEM_RESPONDER_ALIGN_CHK_EN, the err port SHALL be absent and addr[1:0] SHALL be ignored per REQ-018.

Structure
REQ-026 The state encoding (IDLE, WAIT, DONE) and the 32-bit word-width constant SHALL be defined in a shared package mem_responder_pkg.
REQ-027 Storage SHALL be a sub-module mem_responder_array (synchronous write port, combinational read port, DEPTH words).

Verification
REQ-028 Write 0xDEADBEEF to 0x10, LATENCY=2 -> ready high on the 3rd cycle after capture; subsequent read of 0x10 returns 0xDEADBEEF.
REQ-029 Read of 0x400 after a write of 0x12345678 to 0x000 with DEPTH=256 -> returns 0x12345678 (wrap).
REQ-030 mem_read=mem_write=1, addr 0x20, wdata 0xA5A5A5A5 -> treated as a write; a later read of 0x20 returns 0xA5A5A5A5.
REQ-031 rst pulsed during WAIT of a write of 0x11111111 to 0x30 that previously held 0x22222222 -> ready never pulses; a read of 0x30 returns 0x22222222.
REQ-032 LATENCY=0, back-to-back reads held high -> ready pulses every 2 cycles, never on consecutive cycles.
REQ-033 With MEM_RESPONDER_ALIGN_CHK_EN defined, write to 0x13 -> err=1 together with ready; 0x10 is unchanged.

Source files
------------

// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// mem_responder_pkg : shared FSM state encoding and data-word width
// Revision: 1.0
// ============================================================================
package mem_responder_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mem_responder_array.sv
`default_nettype none
// ============================================================================
// mem_responder_array : DEPTH x 32-bit storage, sync write, async read
// Revision: 1.0
// ============================================================================
module mem_responder_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  // Contents deliberately survive reset.
  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// mem_responder : fixed-latency single-outstanding memory responder
// Optional: MEM_RESPONDER_ALIGN_CHK_EN adds err output for misaligned access
// Revision: 1.0
// ============================================================================
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              ready
`ifdef MEM_RESPONDER_ALIGN_CHK_EN
  ,
  output logic              err
`endif
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [AW-1:0]     idx_q;
  logic [WORD_W-1:0] wdata_q;
  logic              is_wr_q;
  logic [WORD_W-1:0] rdata_q, rdata_d;

  logic              w_req;
  logic              w_enter_done;
  logic              w_in_idle;
  logic [AW-1:0]     w_idx;
  logic              w_wr;
  logic [WORD_W-1:0] w_wdata;
  logic [WORD_W-1:0] w_rd_word;
  logic              w_ok;
  logic              w_we;

  assign w_req = mem_read | mem_write;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    w_enter_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_req) begin
          if (LATENCY == 0) begin
            state_d      = DONE;
            w_enter_done = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d      = DONE;
          w_enter_done = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero latency the access completes on the capture edge itself,
  // so the live inputs must feed the array instead of the captured copies.
  assign w_in_idle = (state_q == IDLE);
  assign w_idx     = w_in_idle ? addr[AW+1:2] : idx_q;
  assign w_wr      = w_in_idle ? mem_write    : is_wr_q;
  assign w_wdata   = w_in_idle ? wdata        : wdata_q;

`ifdef MEM_RESPONDER_ALIGN_CHK_EN
  logic misal_q;
  logic w_misal;

  assign w_misal = w_in_idle ? (addr[1:0] != 2'b00) : misal_q;
  assign w_ok    = ~w_misal;
  assign err     = ready & misal_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misal_q <= 1'b0;
    end else if (w_in_idle && w_req) begin
      misal_q <= w_misal;
    end
  end
`else
  assign w_ok = 1'b1;
`endif

  assign w_we    = w_enter_done & w_wr & w_ok;
  assign rdata_d = (w_enter_done & ~w_wr & w_ok) ? w_rd_word : rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      if (w_in_idle && w_req) begin
        idx_q   <= addr[AW+1:2];
        wdata_q <= wdata;
        is_wr_q <= mem_write;
      end
    end
  end

  mem_responder_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .we_i    (w_we),
    .addr_i  (w_idx),
    .wdata_i (w_wdata),
    .rdata_o (w_rd_word)
  );

  assign rdata = rdata_q;
  assign ready = (state_q == DONE);

  // Address bits outside the word index are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[WORD_W-1:AW+2], addr[1:0]};

endmodule
`default_nettype wire
